// File: rtl/sn_pkg.sv
// Shared types and constants for the slave/home node: request/response payloads,
// opcodes and the channel announce state encoding.
package sn_pkg;

  localparam int unsigned WORD_WIDTH = 8;
  localparam int unsigned ADDR_BITS  = 4;
  localparam int unsigned OP_BITS    = 2;

  localparam logic [OP_BITS-1:0] op_read         = 2'd0;
  localparam logic [OP_BITS-1:0] op_data_recv    = 2'd1;
  localparam logic [OP_BITS-1:0] op_no_data_recv = 2'd2;

  typedef struct packed {
    logic [OP_BITS-1:0]   opcode;
    logic [ADDR_BITS-1:0] addr;
  } ReqType;

  typedef struct packed {
    logic [OP_BITS-1:0]    opcode;
    logic [ADDR_BITS-1:0]  addr;
    logic [WORD_WIDTH-1:0] data;
  } DataType;

  typedef enum logic [1:0] {
    StIdle,
    StAsserted,
    StSend
  } Type_chn_state;

  // Only an in-range read returns data; everything else answers with no data.
  function automatic DataType make_resp(input ReqType req, input logic in_range,
                                        input logic [WORD_WIDTH-1:0] word);
    DataType resp;
    resp.addr = req.addr;
    if (req.opcode == op_read && in_range) begin
      resp.opcode = op_data_recv;
      resp.data   = word;
    end else begin
      resp.opcode = op_no_data_recv;
      resp.data   = '0;
    end
    return resp;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous in-order request queue. A push while full is taken only when a pop
// frees a slot in the same cycle.
module req_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [Width-1:0]       wdata,
  input  logic                   pop,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sn.sv
// Slave/home node: queues read requests from the req channel, looks them up in a
// local word memory and answers on the data channel with a pre/valid announce.
module sn
  import sn_pkg::*;
#(
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned MEM_DEPTH  = 4,
  parameter int unsigned PRE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pre_rx_req,
  input  ReqType                rx_req,
  input  logic                  v_rx_req,
  output logic                  pre_tx_data,
  output DataType               tx_data,
  output logic                  v_tx_data,
  input  logic                  cfg_we,
  input  logic [ADDR_BITS-1:0]  cfg_addr,
  input  logic [WORD_WIDTH-1:0] cfg_wdata,
  output logic [7:0]            drop_cnt,
  output logic                  proto_err
);

  localparam int unsigned CntW     = $clog2(QDEPTH) + 1;
  localparam int unsigned MIdxW    = $clog2(MEM_DEPTH);
  localparam int unsigned MemSlots = 1 << MIdxW;

  ReqType          head;
  logic            q_full, q_empty;
  logic [CntW-1:0] q_count;
  logic            push, pop;

  Type_chn_state in_state_q, in_state_d;
  Type_chn_state rsp_state_q, rsp_state_d;
  logic [7:0]    pre_cnt_q, pre_cnt_d;

  logic [WORD_WIDTH-1:0] mem_q [MemSlots];
  logic [WORD_WIDTH-1:0] head_word;
  logic                  head_in_range;

  logic       pre_tx_data_q, v_tx_data_q, proto_err_q;
  DataType    tx_data_q;
  logic [7:0] drop_cnt_q;

  assign pop  = (rsp_state_q == StSend);
  assign push = v_rx_req && (!q_full || pop);

  req_fifo #(
    .Width ($bits(ReqType)),
    .Depth (QDEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (rx_req),
    .pop     (pop),
    .rdata   (head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  always_comb begin
    in_state_d = in_state_q;
    unique case (in_state_q)
      StIdle:     if (pre_rx_req) in_state_d = StAsserted;
      StAsserted: if (v_rx_req) in_state_d = StIdle;
      default:    in_state_d = StIdle;
    endcase
  end

  always_comb begin
    rsp_state_d = rsp_state_q;
    pre_cnt_d   = pre_cnt_q;
    unique case (rsp_state_q)
      StIdle: begin
        if (!q_empty) begin
          rsp_state_d = StAsserted;
          pre_cnt_d   = 8'(PRE_CYCLES - 1);
        end
      end
      StAsserted: begin
        if (pre_cnt_q == '0) rsp_state_d = StSend;
        else                 pre_cnt_d   = pre_cnt_q - 8'd1;
      end
      StSend: begin
        // Another entry remains once the head leaves (a same-cycle push counts).
        if (q_count > CntW'(1) || push) begin
          rsp_state_d = StAsserted;
          pre_cnt_d   = 8'(PRE_CYCLES - 1);
        end else begin
          rsp_state_d = StIdle;
        end
      end
      default: rsp_state_d = StIdle;
    endcase
  end

  // tx_data is captured on entry to StSend; forwarding the write of that cycle gives
  // the memory contents as seen during the StSend cycle itself.
  assign head_in_range = (32'(head.addr) < MEM_DEPTH);
  assign head_word     = (cfg_we && cfg_addr == head.addr) ? cfg_wdata
                                                            : mem_q[head.addr[MIdxW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MemSlots; i++) mem_q[i] <= WORD_WIDTH'(i);
    end else if (cfg_we && 32'(cfg_addr) < MEM_DEPTH) begin
      mem_q[cfg_addr[MIdxW-1:0]] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_state_q    <= StIdle;
      rsp_state_q   <= StIdle;
      pre_cnt_q     <= '0;
      pre_tx_data_q <= 1'b0;
      v_tx_data_q   <= 1'b0;
      tx_data_q     <= '0;
      drop_cnt_q    <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      in_state_q    <= in_state_d;
      rsp_state_q   <= rsp_state_d;
      pre_cnt_q     <= pre_cnt_d;
      pre_tx_data_q <= (rsp_state_d == StAsserted);
      v_tx_data_q   <= (rsp_state_d == StSend);
      if (rsp_state_d == StSend) tx_data_q <= make_resp(head, head_in_range, head_word);
      if (v_rx_req && q_full && !pop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (v_rx_req && in_state_q == StIdle) proto_err_q <= 1'b1;
    end
  end

  assign pre_tx_data = pre_tx_data_q;
  assign v_tx_data   = v_tx_data_q;
  assign tx_data     = tx_data_q;
  assign drop_cnt    = drop_cnt_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_sn.sv
// Bench for sn: two instances (PRE_CYCLES 1 / MEM_DEPTH 3 and PRE_CYCLES 3 / MEM_DEPTH 4)
// driven in parallel and compared every cycle against a queue-and-schedule model.
module tb_sn;
  import sn_pkg::*;

  localparam int QD = 4;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  pre_rx_req, v_rx_req, cfg_we;
  ReqType                rx_req;
  logic [ADDR_BITS-1:0]  cfg_addr;
  logic [WORD_WIDTH-1:0] cfg_wdata;

  logic       pre_a, v_a, perr_a, pre_b, v_b, perr_b;
  DataType    tx_a, tx_b;
  logic [7:0] drop_a, drop_b;

  sn #(.QDEPTH(4), .MEM_DEPTH(3), .PRE_CYCLES(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .pre_rx_req(pre_rx_req), .rx_req(rx_req),
    .v_rx_req(v_rx_req), .pre_tx_data(pre_a), .tx_data(tx_a), .v_tx_data(v_a),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .drop_cnt(drop_a), .proto_err(perr_a)
  );

  sn #(.QDEPTH(4), .MEM_DEPTH(4), .PRE_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .pre_rx_req(pre_rx_req), .rx_req(rx_req),
    .v_rx_req(v_rx_req), .pre_tx_data(pre_b), .tx_data(tx_b), .v_tx_data(v_b),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .drop_cnt(drop_b), .proto_err(perr_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state, one slot per instance.
  int                    pre_c[2] = '{1, 3};
  int                    md[2] = '{3, 4};
  ReqType                mq[2][$];
  int                    next_send[2];
  logic [7:0]            m_drop[2];
  logic                  m_proto[2];
  DataType               m_tx[2];
  logic                  armed[2];
  logic [WORD_WIDTH-1:0] mmem[2][16];

  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [1:0] eop;
    logic [7:0] edata;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, got, exp);
    end
  endtask

  function automatic DataType ref_resp(input int k, input ReqType r);
    DataType d;
    d.addr = r.addr;
    if (r.opcode == op_read && int'(r.addr) < md[k]) begin
      d.opcode = op_data_recv;
      d.data   = mmem[k][r.addr];
    end else begin
      d.opcode = op_no_data_recv;
      d.data   = '0;
    end
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      next_send[k] = -1;
      m_drop[k]    = '0;
      m_proto[k]   = 1'b0;
      m_tx[k]      = '0;
      armed[k]     = 1'b0;
      for (int i = 0; i < 16; i++) mmem[k][i] = 8'(i);
    end
  endtask

  // Apply the inputs of cycle cyc to the model.
  task automatic model_step();
    bit sent;
    for (int k = 0; k < 2; k++) begin
      sent = (next_send[k] == cyc);
      if (sent) void'(mq[k].pop_front());
      else if (next_send[k] < 0 && mq[k].size() > 0) next_send[k] = cyc + 1 + pre_c[k];
      if (v_rx_req) begin
        if (mq[k].size() < QD) mq[k].push_back(rx_req);
        else if (m_drop[k] != 8'hFF) m_drop[k] = m_drop[k] + 8'd1;
      end
      if (sent) next_send[k] = (mq[k].size() > 0) ? cyc + pre_c[k] + 1 : -1;
      if (v_rx_req && !armed[k]) m_proto[k] = 1'b1;
      if (armed[k]) begin
        if (v_rx_req) armed[k] = 1'b0;
      end else if (pre_rx_req) begin
        armed[k] = 1'b1;
      end
      if (cfg_we && int'(cfg_addr) < md[k]) mmem[k][cfg_addr] = cfg_wdata;
      if (next_send[k] == cyc + 1) m_tx[k] = ref_resp(k, mq[k][0]);
    end
  endtask

  task automatic check_outputs();
    logic ep, ev;
    for (int k = 0; k < 2; k++) begin
      ep = (next_send[k] >= 0) && (cyc >= next_send[k] - pre_c[k]) && (cyc < next_send[k]);
      ev = (cyc == next_send[k]);
      chk("pre_tx_data", k, k ? pre_b : pre_a, ep);
      chk("v_tx_data", k, k ? v_b : v_a, ev);
      chk("tx_data", k, k ? tx_b : tx_a, m_tx[k]);
      chk("drop_cnt", k, k ? drop_b : drop_a, m_drop[k]);
      chk("proto_err", k, k ? perr_b : perr_a, m_proto[k]);
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle_inputs();
    pre_rx_req = 1'b0;
    v_rx_req   = 1'b0;
    rx_req     = '0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    cyc++;
    reset_n = 1'b1;
    check_outputs();
  endtask

  task automatic send_req(input logic [1:0] op, input logic [3:0] addr, input bit arm);
    if (arm) begin
      pre_rx_req = 1'b1;
      tick();
      pre_rx_req = 1'b0;
    end
    v_rx_req      = 1'b1;
    rx_req.opcode = op;
    rx_req.addr   = addr;
    tick();
    v_rx_req = 1'b0;
  endtask

  task automatic wait_va(input int limit);
    int w = 0;
    while (!v_a && w < limit) begin
      tick();
      w++;
    end
  endtask

  initial begin
    int t0, pre_run, vb_cnt, last_v;
    int got_addr[$];
    int got_cyc[$];

    tbl[0] = '{op_read, 4'd1, op_data_recv, 8'h01};
    tbl[1] = '{op_read, 4'd0, op_data_recv, 8'h00};
    tbl[2] = '{op_read, 4'd2, op_data_recv, 8'h02};
    tbl[3] = '{op_read, 4'd3, op_no_data_recv, 8'h00};
    tbl[4] = '{op_read, 4'd15, op_no_data_recv, 8'h00};
    tbl[5] = '{2'd3, 4'd1, op_no_data_recv, 8'h00};
    tbl[6] = '{op_data_recv, 4'd2, op_no_data_recv, 8'h00};

    idle_inputs();
    @(negedge clk);
    do_reset();
    chk("reset_v", 0, v_a, 1'b0);
    chk("reset_tx", 0, tx_a, '0);

    // Single requests from idle: latency T+3 on dut_a and the response content.
    foreach (tbl[i]) begin
      repeat (6) tick();
      send_req(tbl[i].op, tbl[i].addr, 1'b1);
      t0 = cyc - 1;
      wait_va(10);
      chk("tbl_latency", 0, cyc - t0, 3);
      chk("tbl_opcode", 0, tx_a.opcode, tbl[i].eop);
      chk("tbl_addr", 0, tx_a.addr, tbl[i].addr);
      chk("tbl_data", 0, tx_a.data, tbl[i].edata);
    end

    // Local write then read back.
    repeat (6) tick();
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 8'hA5;
    tick();
    cfg_we = 1'b0;
    send_req(op_read, 4'd2, 1'b1);
    wait_va(10);
    chk("cfg_readback", 0, tx_a.data, 8'hA5);

    // Write in the StSend cycle of a read of the same address returns the old word.
    repeat (8) tick();
    send_req(op_read, 4'd2, 1'b1);
    tick();
    tick();
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 8'h5A;
    chk("stsend_valid", 0, v_a, 1'b1);
    chk("stsend_old_data", 0, tx_a.data, 8'hA5);
    tick();
    cfg_we = 1'b0;
    chk("tx_held", 0, tx_a.data, 8'hA5);
    repeat (8) tick();
    send_req(op_read, 4'd2, 1'b1);
    wait_va(10);
    chk("stsend_new_data", 0, tx_a.data, 8'h5A);

    // A write one cycle before StSend is visible in the response.
    repeat (8) tick();
    send_req(op_read, 4'd2, 1'b1);
    tick();
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 8'h3C;
    tick();
    cfg_we = 1'b0;
    chk("pre_send_write", 0, tx_a.data, 8'h3C);

    // PRE_CYCLES=3: exactly three announce cycles, low in the valid cycle.
    repeat (10) tick();
    send_req(op_read, 4'd1, 1'b1);
    pre_run = 0;
    for (int w = 0; w < 12 && !v_b; w++) begin
      if (pre_b) pre_run++;
      tick();
    end
    chk("pre3_valid_seen", 1, v_b, 1'b1);
    chk("pre3_low_in_valid", 1, pre_b, 1'b0);
    chk("pre3_run", 1, pre_run, 3);

    // Six back-to-back requests without announce.
    repeat (10) tick();
    for (int i = 0; i < 6; i++) begin
      v_rx_req = 1'b1; rx_req.opcode = op_read; rx_req.addr = 4'(i);
      if (v_a) begin got_addr.push_back(int'(tx_a.addr)); got_cyc.push_back(cyc); end
      tick();
    end
    v_rx_req = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (v_a) begin got_addr.push_back(int'(tx_a.addr)); got_cyc.push_back(cyc); end
      tick();
    end
    chk("burst_proto_err", 0, perr_a, 1'b1);
    chk("burst_drop_a", 0, drop_a, 8'd0);
    chk("burst_drop_b", 1, drop_b, 8'd1);
    chk("burst_count", 0, got_addr.size(), 6);
    for (int i = 0; i < got_addr.size(); i++) begin
      chk("burst_order", 0, got_addr[i], i);
      if (i > 0) chk("burst_spacing", 0, got_cyc[i] - got_cyc[i-1], 2);
    end

    // Saturating drop counter.
    v_rx_req = 1'b1; rx_req.opcode = op_read; rx_req.addr = 4'd1;
    repeat (600) tick();
    v_rx_req = 1'b0;
    chk("drop_sat_a", 0, drop_a, 8'hFF);
    chk("drop_sat_b", 1, drop_b, 8'hFF);
    repeat (20) tick();

    // Randomised traffic with local writes.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      pre_rx_req    = ($urandom_range(0, 2) == 0);
      v_rx_req      = ($urandom_range(0, 2) == 0);
      rx_req.opcode = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : op_read;
      rx_req.addr   = 4'($urandom_range(0, 5));
      cfg_we        = ($urandom_range(0, 7) == 0);
      cfg_addr      = 4'($urandom_range(0, 5));
      cfg_wdata     = 8'($urandom);
      tick();
    end
    idle_inputs();
    repeat (30) tick();

    // Reset while three requests are queued: everything is lost.
    do_reset();
    send_req(op_read, 4'd1, 1'b1);
    v_rx_req = 1'b1; rx_req.addr = 4'd2;
    tick();
    rx_req.addr = 4'd0;
    tick();
    v_rx_req = 1'b0;
    chk("queued_before_reset", 0, mq[0].size(), 3);
    do_reset();
    chk("midrst_pre", 0, pre_a, 1'b0);
    chk("midrst_v", 0, v_a, 1'b0);
    chk("midrst_tx", 0, tx_a, '0);
    chk("midrst_drop", 0, drop_a, 8'd0);
    chk("midrst_proto", 0, perr_a, 1'b0);
    vb_cnt = 0;
    last_v = 0;
    for (int w = 0; w < 15; w++) begin
      tick();
      if (v_a || v_b) vb_cnt++;
      last_v = last_v | int'(pre_a) | int'(pre_b);
    end
    chk("midrst_no_resp", 0, vb_cnt, 0);
    chk("midrst_no_pre", 0, last_v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
